fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one FIFO write port between NREQ requesters.
- Each requester presents a valid/ready stream: req[i] with req_data, and accept[i] as the ready.
- The arbiter grants one owner at a time for a burst of up to MAX_BURST words.
- It drives the FIFO wr_en/data_in from registers, uses full/almostfull to prevent overflow, and flags any overflow reported by the FIFO.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FIFO_WIDTH, 16, data word width.
- MAX_BURST, 4, maximum words per grant before the arbiter must rotate (1..15).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester valid.
- req_data  in  NREQ*FIFO_WIDTH  requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- accept  out  NREQ  combinational ready; the word is consumed at the edge where req[i] and accept[i] are both high.
- gnt  out  NREQ  registered one-hot current owner; all zero when idle.
- fifo_wr_en  out  1  registered FIFO write enable.
- fifo_data_in  out  FIFO_WIDTH  registered FIFO write data.
- fifo_full  in  1  FIFO full.
- fifo_almostfull  in  1  FIFO almost full (one slot left).
- fifo_wr_ack  in  1  FIFO write acknowledge; counted for statistics only.
- fifo_overflow  in  1  FIFO overflow indication.
- ovf_err  out  1  sticky; set when fifo_overflow=1 is sampled.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - Next-cycle values: state=IDLE, gnt=0, fifo_wr_en=0, fifo_data_in=0, ovf_err=0, busy=0.
  - Also clears: rr_ptr=0, burst_cnt=0.
  - accept=0 while rst=1.
  - Reset mid-burst drops the burst; words not yet accepted remain the requester's responsibility.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - If any req is high, select the first set req at or after rr_ptr, wrapping NREQ-1 -> 0.
  - Next state GRANT; gnt <= onehot(sel); burst_cnt <= 0.
  - accept is 0 in IDLE, so grant latency is 1 cycle and the first write is presented 2 edges after req is first seen.
- can_write = !fifo_full && !(fifo_wr_en && fifo_almostfull).
  - The second term covers the write already in flight, so a registered write never lands on a full FIFO.
- GRANT, owner o:
  - accept[o] = req[o] && can_write; all other accept bits are 0.
  - On an accept edge: fifo_wr_en <= 1, fifo_data_in <= req_data[o], burst_cnt <= burst_cnt+1.
  - Otherwise fifo_wr_en <= 0; fifo_data_in holds its value.
  - Go to DRAIN when req[o] falls while not accepting, or when an accept makes burst_cnt reach MAX_BURST.
  - When the FIFO is full, stay in GRANT with no writes and no timeout (stall).
- DRAIN (1 cycle):
  - fifo_wr_en <= 0; gnt <= 0; rr_ptr <= (o+1) mod NREQ; next state IDLE.
  - This gives a 1-cycle bubble between owners.
- Fairness: a requester that is continuously requesting waits at most (NREQ-1)*(MAX_BURST+2) cycles of non-stalled operation before being granted.
- ovf_err <= ovf_err | fifo_overflow. Cleared only by rst.
- Simultaneous events:
  - req[o] falling on the same edge that burst_cnt reaches MAX_BURST goes to a single DRAIN.
  - fifo_full rising mid-burst freezes burst_cnt.
  - gnt changes only on the IDLE->GRANT and DRAIN->IDLE transitions.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined: adds outputs wr_count (16 bits), incremented on each fifo_wr_ack=1, and stall_count (16 bits), incremented on each GRANT cycle with req[o]=1 and can_write=0.
  - Both saturate at 16'hFFFF and are cleared by rst.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset priority: after rst, req=4'b1111 held, FIFO never full -> grant order 0,1,2,3,0.
  - Each owner gets exactly 4 writes.
  - fifo_wr_en pattern per owner: 0,1,1,1,1,0 (bubble in DRAIN).
- Single requester: req[2]=1 for 3 words, then 0 -> fifo_data_in sequence matches the 3 words, then DRAIN, then IDLE with rr_ptr=3.
  - busy falls 2 cycles after the last accept.
- Backpressure: fifo_almostfull=1 while fifo_wr_en=1 -> accept=0 that cycle.
  - fifo_full=1 for 5 cycles -> no fifo_wr_en; gnt and burst_cnt held; writes resume the cycle after full=0.
- Wrap-around: req=4'b1001, owner 3 finishes -> rr_ptr=0, next gnt=4'b0001, then gnt=4'b1000.
- Reset mid-burst: rst=1 after 2 of 4 writes -> next cycle gnt=0, fifo_wr_en=0, busy=0; after release, req=4'b0100 is granted from rr_ptr=0.
- Overflow / stats: inject fifo_overflow=1 for one cycle -> ovf_err=1 until rst.
  - With FIFO_WR_ARB_STATS_EN: 10 acks -> wr_count=10; 5 stalled cycles -> stall_count=5.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one registered FIFO write port among NREQ valid/ready requesters.
// Define FIFO_WR_ARB_STATS_EN to add saturating wr_count / stall_count statistics outputs.
module fifo_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*FIFO_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            accept,
    output logic [NREQ-1:0]            gnt,
    output logic                       fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]      fifo_data_in,
    input  logic                       fifo_full,
    input  logic                       fifo_almostfull,
    input  logic                       fifo_wr_ack,
    input  logic                       fifo_overflow,
    output logic                       ovf_err,
    output logic                       busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]                wr_count,
    output logic [15:0]                stall_count
`endif
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       sel;
    logic                   sel_vld;
    logic [3:0]             burst_cnt;
    logic                   can_write;
    logic                   take;
    logic                   last_word;
    logic [FIFO_WIDTH-1:0]  owner_data;

    // Search from rr_ptr upward with wrap; iterating downward lets the nearest hit win.
    always_comb begin
        int idx;
        idx     = 0;
        sel     = '0;
        sel_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                sel     = IDX_W'(idx);
                sel_vld = 1'b1;
            end
        end
    end

    // The second term accounts for a write already registered but not yet seen by the FIFO.
    assign can_write  = !fifo_full && !(fifo_wr_en && fifo_almostfull);
    assign take       = (state == GRANT) && req[owner] && can_write && !rst;
    assign last_word  = (burst_cnt == 4'(MAX_BURST - 1));
    assign owner_data = req_data[int'(owner)*FIFO_WIDTH +: FIFO_WIDTH];
    assign busy       = (state != IDLE);

    always_comb begin
        accept        = '0;
        accept[owner] = take;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_vld) state_nxt = GRANT;
            GRANT:   if ((take && last_word) || !req[owner]) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt          <= '0;
            owner        <= '0;
            rr_ptr       <= '0;
            burst_cnt    <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            ovf_err      <= 1'b0;
        end else begin
            ovf_err    <= ovf_err | fifo_overflow;
            fifo_wr_en <= take;
            if (take) begin
                fifo_data_in <= owner_data;
                burst_cnt    <= burst_cnt + 4'd1;
            end
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        owner     <= sel;
                        gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << sel;
                        burst_cnt <= '0;
                    end
                end
                DRAIN: begin
                    gnt <= '0;
                    if (int'(owner) == NREQ - 1) rr_ptr <= '0;
                    else                         rr_ptr <= owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    // Stall means the owner has a word ready but the FIFO cannot take it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            if (fifo_wr_ack && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
            if (state == GRANT && req[owner] && !can_write && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a transaction-level reference model.
// Honours FIFO_WR_ARB_STATS_EN for the optional statistics outputs.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int FW   = 16;
    localparam int MB   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*FW-1:0]   req_data;
    logic [NREQ-1:0]      accept;
    logic [NREQ-1:0]      gnt;
    logic                 fifo_wr_en;
    logic [FW-1:0]        fifo_data_in;
    logic                 fifo_full;
    logic                 fifo_almostfull;
    logic                 fifo_wr_ack;
    logic                 fifo_overflow;
    logic                 ovf_err;
    logic                 busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]          wr_count;
    logic [15:0]          stall_count;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(NREQ), .FIFO_WIDTH(FW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .accept(accept),
        .gnt(gnt), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
        .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
        .ovf_err(ovf_err), .busy(busy)
`ifdef FIFO_WR_ARB_STATS_EN
        , .wr_count(wr_count), .stall_count(stall_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the port, how many words it has written, whether
    // its turn is over, and whose turn is next.
    int          m_owner;
    int          m_words;
    int          m_next;
    bit          m_done;
    bit          m_wr_en;
    logic [FW-1:0] m_data;
    bit          m_ovf;
    int          m_wrc;
    int          m_stall;

    int          glog[$];
    int          wcount[NREQ];
    logic [NREQ-1:0] prev_gnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic bit room();
        return !fifo_full && !(m_wr_en && fifo_almostfull);
    endfunction

    function automatic logic [NREQ-1:0] exp_accept();
        logic [NREQ-1:0] a;
        a = '0;
        if (!rst && m_owner >= 0 && !m_done && req[m_owner] && room())
            a[m_owner] = 1'b1;
        return a;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_words = 0; m_next = 0; m_done = 0;
        m_wr_en = 0; m_data = '0; m_ovf = 0; m_wrc = 0; m_stall = 0;
    endtask

    task automatic model_edge();
        logic [NREQ-1:0] acc;
        bit found;
        acc = exp_accept();
        if (rst) begin
            model_reset();
            return;
        end
        m_ovf = m_ovf | fifo_overflow;
        if (fifo_wr_ack && m_wrc < 65535) m_wrc++;
        if (m_owner >= 0 && !m_done && req[m_owner] && !room() && m_stall < 65535) m_stall++;
        if (m_owner < 0) begin
            m_wr_en = 0;
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req[(m_next + k) % NREQ]) begin
                    m_owner = (m_next + k) % NREQ;
                    found = 1;
                end
            end
            m_words = 0;
            m_done  = 0;
        end else if (m_done) begin
            m_wr_en = 0;
            m_next  = (m_owner + 1) % NREQ;
            m_owner = -1;
            m_done  = 0;
        end else if (acc != 0) begin
            m_wr_en = 1;
            m_data  = req_data[m_owner*FW +: FW];
            m_words++;
            if (m_words == MB) m_done = 1;
        end else begin
            m_wr_en = 0;
            if (!req[m_owner]) m_done = 1;
        end
    endtask

    // One clock: caller has set control inputs at the falling edge.
    task automatic tick();
        logic [NREQ-1:0] eg;
        int gi;
        for (int i = 0; i < NREQ; i++) req_data[i*FW +: FW] = FW'($urandom);
        #1;
        check("accept", 32'(accept), 32'(exp_accept()));
        @(posedge clk);
        model_edge();
        #1;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check("gnt", 32'(gnt), 32'(eg));
        check("wr_en", 32'(fifo_wr_en), 32'(m_wr_en));
        check("data_in", 32'(fifo_data_in), 32'(m_data));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("ovf_err", 32'(ovf_err), 32'(m_ovf));
`ifdef FIFO_WR_ARB_STATS_EN
        check("wr_count", 32'(wr_count), 32'(m_wrc));
        check("stall_count", 32'(stall_count), 32'(m_stall));
`endif
        gi = onehot_idx(gnt);
        if (prev_gnt == '0 && gnt != '0) glog.push_back(gi);
        if (fifo_wr_en && gi >= 0) wcount[gi]++;
        prev_gnt = gnt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic int glog_at(input int i);
        return (glog.size() > i) ? glog[i] : -1;
    endfunction

    initial begin
        rst = 1'b1; req = '0; req_data = '0; fifo_full = 0; fifo_almostfull = 0;
        fifo_wr_ack = 0; fifo_overflow = 0; prev_gnt = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);

        // Reset state and accept held low during reset with all requesting.
        req = 4'b1111;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Full rotation from reset: order 0,1,2,3,0 with four writes each.
        glog.delete();
        for (int i = 0; i < NREQ; i++) wcount[i] = 0;
        repeat (25) tick();
        check("order0", 32'(glog_at(0)), 32'd0);
        check("order1", 32'(glog_at(1)), 32'd1);
        check("order2", 32'(glog_at(2)), 32'd2);
        check("order3", 32'(glog_at(3)), 32'd3);
        check("order4", 32'(glog_at(4)), 32'd0);
        for (int i = 0; i < NREQ; i++) check("burst_words", 32'(wcount[i]), 32'(MB));

        // Single requester, short burst, then pointer must sit at 3.
        req = '0;
        do_reset();
        req = 4'b0100;
        repeat (4) tick();
        req = '0;
        repeat (3) tick();
        glog.delete();
        req = 4'b1111;
        tick();
        check("rr_after_single", 32'(glog_at(0)), 32'd3);

        // Backpressure: almost-full alternates writes; full stalls five cycles.
        req = '0;
        do_reset();
        req = 4'b0001;
        fifo_almostfull = 1;
        repeat (8) tick();
        fifo_almostfull = 0;
        tick();
        tick();
        fifo_full = 1;
        repeat (5) tick();
        fifo_full = 0;
        repeat (6) tick();

        // Wrap-around between requesters 0 and 3.
        req = '0;
        do_reset();
        glog.delete();
        req = 4'b1001;
        repeat (14) tick();
        check("wrap0", 32'(glog_at(0)), 32'd0);
        check("wrap1", 32'(glog_at(1)), 32'd3);
        check("wrap2", 32'(glog_at(2)), 32'd0);

        // Reset after two writes of a burst; pointer restarts at 0.
        req = '0;
        do_reset();
        req = 4'b1111;
        repeat (3) tick();
        do_reset();
        glog.delete();
        req = 4'b0100;
        repeat (3) tick();
        check("post_rst_grant", 32'(glog_at(0)), 32'd2);

        // Sticky overflow, plus a run of acknowledges for the statistics.
        fifo_overflow = 1;
        tick();
        fifo_overflow = 0;
        fifo_wr_ack = 1;
        repeat (10) tick();
        fifo_wr_ack = 0;
        repeat (3) tick();
        do_reset();

        // Randomized traffic with occasional full, almost-full, overflow and reset.
        for (int n = 0; n < 3000; n++) begin
            req             = NREQ'($urandom);
            fifo_full       = ($urandom_range(0, 4) == 0);
            fifo_almostfull = ($urandom_range(0, 2) == 0);
            fifo_wr_ack     = $urandom_range(0, 1);
            fifo_overflow   = ($urandom_range(0, 99) == 0);
            rst             = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
